// File: rtl/damage_apply.sv
// Applies round damage totals front-to-back against each side's health array.
// Overkill carries into the next live unit. Results are held until Ack.
module damage_apply #(
  parameter int N     = 16,
  parameter int HP_W  = 8,
  parameter int DMG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Ack,
  input  logic [DMG_W-1:0] totalUnitDamage,
  input  logic [DMG_W-1:0] totalEnemyDamage,
  input  logic             wrEn,
  input  logic             wrSide,
  input  logic [3:0]       wrIdx,
  input  logic [HP_W-1:0]  wrHp,
  input  logic             rdSide,
  input  logic [3:0]       rdIdx,
  output logic [HP_W-1:0]  rdHp,
  output logic [N-1:0]     unitAlive,
  output logic [N-1:0]     enemyAlive,
  output logic [4:0]       unitKills,
  output logic [4:0]       enemyKills,
  output logic [DMG_W-1:0] unitLeftover,
  output logic [DMG_W-1:0] enemyLeftover,
  output logic             enemiesWiped,
  output logic             unitsWiped,
  output logic             Done
);

  typedef enum logic [1:0] {S_INIT, S_APPLY, S_DONE} state_t;

  state_t state, state_n;

  logic [HP_W-1:0]  hp_f [N];
  logic [HP_W-1:0]  hp_e [N];
  logic [4:0]       ptr_f, ptr_e;
  logic [DMG_W-1:0] rem_f, rem_e;
  logic [HP_W-1:0]  cur_f, cur_e;
  logic             fin_f, fin_e;

  // ptr == N is the "side exhausted" marker; low bits wrap to 0 there but
  // the unit is never touched because fin_* gates all updates.
  assign cur_f = hp_f[ptr_f[3:0]];
  assign cur_e = hp_e[ptr_e[3:0]];
  assign fin_f = (rem_f == '0) || (ptr_f == 5'(N));
  assign fin_e = (rem_e == '0) || (ptr_e == 5'(N));

  assign rdHp = rdSide ? hp_e[rdIdx] : hp_f[rdIdx];

  always_comb begin
    unitAlive  = '0;
    enemyAlive = '0;
    for (int unsigned i = 0; i < N; i++) begin
      unitAlive[i]  = (hp_f[i] != '0);
      enemyAlive[i] = (hp_e[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_INIT:  if (Start)          state_n = S_APPLY;
      S_APPLY: if (fin_f && fin_e) state_n = S_DONE;
      S_DONE:  if (Ack)            state_n = S_INIT;
      default:                     state_n = S_INIT;
    endcase
  end

  always_comb begin
    Done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        hp_f[i] <= '0;
        hp_e[i] <= '0;
      end
      ptr_f         <= '0;
      ptr_e         <= '0;
      rem_f         <= '0;
      rem_e         <= '0;
      unitKills     <= '0;
      enemyKills    <= '0;
      unitLeftover  <= '0;
      enemyLeftover <= '0;
      enemiesWiped  <= 1'b0;
      unitsWiped    <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (wrEn) begin
            if (wrSide) hp_e[wrIdx] <= wrHp;
            else        hp_f[wrIdx] <= wrHp;
          end
          if (Start) begin
            rem_e         <= totalUnitDamage;
            rem_f         <= totalEnemyDamage;
            ptr_e         <= '0;
            ptr_f         <= '0;
            unitKills     <= '0;
            enemyKills    <= '0;
            unitLeftover  <= '0;
            enemyLeftover <= '0;
          end
        end
        S_APPLY: begin
          if (fin_f && fin_e) begin
            unitLeftover  <= (ptr_e == 5'(N)) ? rem_e : '0;
            enemyLeftover <= (ptr_f == 5'(N)) ? rem_f : '0;
            enemiesWiped  <= (enemyAlive == '0);
            unitsWiped    <= (unitAlive == '0);
          end else begin
            if (!fin_e) begin
              if (cur_e == '0) begin
                ptr_e <= ptr_e + 5'd1;
              end else if (rem_e >= {{(DMG_W-HP_W){1'b0}}, cur_e}) begin
                rem_e              <= rem_e - {{(DMG_W-HP_W){1'b0}}, cur_e};
                hp_e[ptr_e[3:0]]   <= '0;
                unitKills          <= unitKills + 5'd1;
                ptr_e              <= ptr_e + 5'd1;
              end else begin
                hp_e[ptr_e[3:0]]   <= cur_e - rem_e[HP_W-1:0];
                rem_e              <= '0;
              end
            end
            if (!fin_f) begin
              if (cur_f == '0) begin
                ptr_f <= ptr_f + 5'd1;
              end else if (rem_f >= {{(DMG_W-HP_W){1'b0}}, cur_f}) begin
                rem_f              <= rem_f - {{(DMG_W-HP_W){1'b0}}, cur_f};
                hp_f[ptr_f[3:0]]   <= '0;
                enemyKills         <= enemyKills + 5'd1;
                ptr_f              <= ptr_f + 5'd1;
              end else begin
                hp_f[ptr_f[3:0]]   <= cur_f - rem_f[HP_W-1:0];
                rem_f              <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_damage_apply.sv
// Directed bench for damage_apply: nominal, zero, wipe, dead-skip,
// handshake and mid-apply reset scenarios.
module tb_damage_apply;

  logic        clk = 1'b0;
  logic        rst, Start, Ack, wrEn, wrSide, rdSide;
  logic [11:0] totalUnitDamage, totalEnemyDamage;
  logic [3:0]  wrIdx, rdIdx;
  logic [7:0]  wrHp, rdHp;
  logic [15:0] unitAlive, enemyAlive;
  logic [4:0]  unitKills, enemyKills;
  logic [11:0] unitLeftover, enemyLeftover;
  logic        enemiesWiped, unitsWiped, Done;

  int total = 0;
  int bad   = 0;

  damage_apply #(.N(16), .HP_W(8), .DMG_W(12)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Ack(Ack),
    .totalUnitDamage(totalUnitDamage), .totalEnemyDamage(totalEnemyDamage),
    .wrEn(wrEn), .wrSide(wrSide), .wrIdx(wrIdx), .wrHp(wrHp),
    .rdSide(rdSide), .rdIdx(rdIdx), .rdHp(rdHp),
    .unitAlive(unitAlive), .enemyAlive(enemyAlive),
    .unitKills(unitKills), .enemyKills(enemyKills),
    .unitLeftover(unitLeftover), .enemyLeftover(enemyLeftover),
    .enemiesWiped(enemiesWiped), .unitsWiped(unitsWiped), .Done(Done)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: each starts and ends just after a falling edge.
  task automatic write_hp(input logic s, input int i, input logic [7:0] v);
    wrEn = 1'b1; wrSide = s; wrIdx = 4'(i); wrHp = v;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic fill(input logic s, input logic [7:0] v);
    for (int i = 0; i < 16; i++) write_hp(s, i, v);
  endtask

  task automatic do_start(input logic [11:0] ud, input logic [11:0] ed);
    Start = 1'b1; totalUnitDamage = ud; totalEnemyDamage = ed;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
  endtask

  // Counts edges after the Start edge until Done; bounded at 40.
  task automatic wait_done(output int n);
    n = 1;
    @(negedge clk);
    while (Done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic rd(input logic s, input int i, output logic [7:0] v);
    rdSide = s; rdIdx = 4'(i);
    #1;
    v = rdHp;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", Done); end
    total++; if (unitAlive !== 16'h0) begin bad++; $display("FAIL reset_unitAlive got=%0h exp=0", unitAlive); end
    total++; if (enemyAlive !== 16'h0) begin bad++; $display("FAIL reset_enemyAlive got=%0h exp=0", enemyAlive); end
    total++; if (unitKills !== 5'd0 || enemyKills !== 5'd0) begin bad++; $display("FAIL reset_kills got=%0d/%0d exp=0/0", unitKills, enemyKills); end
    total++; if (unitLeftover !== 12'd0 || enemyLeftover !== 12'd0) begin bad++; $display("FAIL reset_leftover got=%0d/%0d exp=0/0", unitLeftover, enemyLeftover); end
    total++; if (enemiesWiped !== 1'b0 || unitsWiped !== 1'b0) begin bad++; $display("FAIL reset_wiped got=%0b/%0b exp=0/0", enemiesWiped, unitsWiped); end
    rd(1'b1, 5, v);
    total++; if (v !== 8'd0) begin bad++; $display("FAIL reset_rdhp got=%0d exp=0", v); end
  endtask

  task automatic test_nominal();
    int n;
    logic [7:0] v;
    fill(1'b0, 8'd20);
    fill(1'b1, 8'd20);
    do_start(12'd150, 12'd140);
    wait_done(n);
    total++; if (n !== 9) begin bad++; $display("FAIL nom_latency got=%0d exp=9", n); end
    for (int i = 0; i < 16; i++) begin
      rd(1'b1, i, v);
      total++; if (v !== ((i < 7) ? 8'd0 : (i == 7) ? 8'd10 : 8'd20)) begin bad++; $display("FAIL nom_enemy_hp[%0d] got=%0d", i, v); end
      rd(1'b0, i, v);
      total++; if (v !== ((i < 7) ? 8'd0 : 8'd20)) begin bad++; $display("FAIL nom_friend_hp[%0d] got=%0d", i, v); end
    end
    total++; if (unitKills !== 5'd7) begin bad++; $display("FAIL nom_unitKills got=%0d exp=7", unitKills); end
    total++; if (enemyKills !== 5'd7) begin bad++; $display("FAIL nom_enemyKills got=%0d exp=7", enemyKills); end
    total++; if (unitLeftover !== 12'd0 || enemyLeftover !== 12'd0) begin bad++; $display("FAIL nom_leftover got=%0d/%0d exp=0/0", unitLeftover, enemyLeftover); end
    total++; if (enemyAlive !== 16'hFF80) begin bad++; $display("FAIL nom_enemyAlive got=%0h exp=ff80", enemyAlive); end
    total++; if (unitAlive !== 16'hFF80) begin bad++; $display("FAIL nom_unitAlive got=%0h exp=ff80", unitAlive); end
    total++; if (enemiesWiped !== 1'b0 || unitsWiped !== 1'b0) begin bad++; $display("FAIL nom_wiped got=%0b/%0b exp=0/0", enemiesWiped, unitsWiped); end
    do_ack();
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL nom_ack_done got=%0b exp=0", Done); end
  endtask

  task automatic test_zero();
    int n;
    logic [7:0] v;
    do_start(12'd0, 12'd0);
    wait_done(n);
    total++; if (n !== 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", n); end
    total++; if (unitKills !== 5'd0 || enemyKills !== 5'd0) begin bad++; $display("FAIL zero_kills got=%0d/%0d exp=0/0", unitKills, enemyKills); end
    rd(1'b1, 7, v);
    total++; if (v !== 8'd10) begin bad++; $display("FAIL zero_enemy_hp7 got=%0d exp=10", v); end
    rd(1'b0, 9, v);
    total++; if (v !== 8'd20) begin bad++; $display("FAIL zero_friend_hp9 got=%0d exp=20", v); end
    total++; if (enemiesWiped !== 1'b0 || unitsWiped !== 1'b0) begin bad++; $display("FAIL zero_wiped got=%0b/%0b exp=0/0", enemiesWiped, unitsWiped); end
    do_ack();
  endtask

  task automatic test_wipe();
    int n;
    fill(1'b1, 8'd5);
    fill(1'b0, 8'd3);
    do_start(12'd100, 12'd60);
    wait_done(n);
    total++; if (n !== 17) begin bad++; $display("FAIL wipe_latency got=%0d exp=17", n); end
    total++; if (unitKills !== 5'd16) begin bad++; $display("FAIL wipe_unitKills got=%0d exp=16", unitKills); end
    total++; if (unitLeftover !== 12'd20) begin bad++; $display("FAIL wipe_unitLeftover got=%0d exp=20", unitLeftover); end
    total++; if (enemyKills !== 5'd16) begin bad++; $display("FAIL wipe_enemyKills got=%0d exp=16", enemyKills); end
    total++; if (enemyLeftover !== 12'd12) begin bad++; $display("FAIL wipe_enemyLeftover got=%0d exp=12", enemyLeftover); end
    total++; if (enemiesWiped !== 1'b1 || unitsWiped !== 1'b1) begin bad++; $display("FAIL wipe_flags got=%0b/%0b exp=1/1", enemiesWiped, unitsWiped); end
    total++; if (enemyAlive !== 16'h0 || unitAlive !== 16'h0) begin bad++; $display("FAIL wipe_alive got=%0h/%0h exp=0/0", enemyAlive, unitAlive); end
    do_ack();
  endtask

  task automatic test_skip_dead();
    int n;
    logic [7:0] v;
    fill(1'b1, 8'd10);
    fill(1'b0, 8'd20);
    write_hp(1'b1, 0, 8'd0);
    write_hp(1'b1, 1, 8'd0);
    // hp[2] written on the same edge that takes Start
    wrEn = 1'b1; wrSide = 1'b1; wrIdx = 4'd2; wrHp = 8'd30;
    do_start(12'd30, 12'd0);
    wrEn = 1'b0;
    wait_done(n);
    total++; if (n !== 4) begin bad++; $display("FAIL skip_latency got=%0d exp=4", n); end
    total++; if (unitKills !== 5'd1) begin bad++; $display("FAIL skip_unitKills got=%0d exp=1", unitKills); end
    total++; if (unitLeftover !== 12'd0) begin bad++; $display("FAIL skip_leftover got=%0d exp=0", unitLeftover); end
    rd(1'b1, 2, v);
    total++; if (v !== 8'd0) begin bad++; $display("FAIL skip_hp2 got=%0d exp=0", v); end
    rd(1'b1, 3, v);
    total++; if (v !== 8'd10) begin bad++; $display("FAIL skip_hp3 got=%0d exp=10", v); end
    total++; if (enemyAlive !== 16'hFFF8) begin bad++; $display("FAIL skip_enemyAlive got=%0h exp=fff8", enemyAlive); end
    do_ack();
  endtask

  task automatic test_handshake();
    int n;
    logic [7:0] v;
    fill(1'b0, 8'd20);
    fill(1'b1, 8'd20);
    do_start(12'd150, 12'd140);
    @(negedge clk);
    wrEn = 1'b1; wrSide = 1'b1; wrIdx = 4'd15; wrHp = 8'd99;
    repeat (2) @(negedge clk);
    wrEn = 1'b0;
    wait_done(n);
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL hs_done_timeout got=%0b exp=1", Done); end
    rd(1'b1, 15, v);
    total++; if (v !== 8'd20) begin bad++; $display("FAIL hs_apply_write got=%0d exp=20", v); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (Done !== 1'b1) begin bad++; $display("FAIL hs_done_hold[%0d] got=%0b exp=1", i, Done); end
    end
    do_start(12'd200, 12'd200);
    @(negedge clk);
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL hs_restart_done got=%0b exp=1", Done); end
    total++; if (unitKills !== 5'd7 || enemyKills !== 5'd7) begin bad++; $display("FAIL hs_restart_kills got=%0d/%0d exp=7/7", unitKills, enemyKills); end
    rd(1'b1, 8, v);
    total++; if (v !== 8'd20) begin bad++; $display("FAIL hs_restart_hp8 got=%0d exp=20", v); end
    do_ack();
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL hs_ack_done got=%0b exp=0", Done); end
    // enemy 0..6 dead, hp[7] = 10: the new damage kills exactly hp[7]
    do_start(12'd10, 12'd0);
    wait_done(n);
    total++; if (n !== 9) begin bad++; $display("FAIL hs_second_latency got=%0d exp=9", n); end
    total++; if (unitKills !== 5'd1) begin bad++; $display("FAIL hs_second_kills got=%0d exp=1", unitKills); end
    total++; if (enemyAlive !== 16'hFF00) begin bad++; $display("FAIL hs_second_alive got=%0h exp=ff00", enemyAlive); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [7:0] v;
    fill(1'b0, 8'd20);
    fill(1'b1, 8'd20);
    do_start(12'd150, 12'd140);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL mid_done got=%0b exp=0", Done); end
    total++; if (unitAlive !== 16'h0 || enemyAlive !== 16'h0) begin bad++; $display("FAIL mid_alive got=%0h/%0h exp=0/0", unitAlive, enemyAlive); end
    rd(1'b0, 0, v);
    total++; if (v !== 8'd0) begin bad++; $display("FAIL mid_hp0 got=%0d exp=0", v); end
    total++; if (unitKills !== 5'd0 || enemyKills !== 5'd0) begin bad++; $display("FAIL mid_kills got=%0d/%0d exp=0/0", unitKills, enemyKills); end
    do_start(12'd50, 12'd50);
    wait_done(n);
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL mid_done_timeout got=%0b exp=1", Done); end
    total++; if (unitKills !== 5'd0 || enemyKills !== 5'd0) begin bad++; $display("FAIL mid2_kills got=%0d/%0d exp=0/0", unitKills, enemyKills); end
    total++; if (unitLeftover !== 12'd50 || enemyLeftover !== 12'd50) begin bad++; $display("FAIL mid2_leftover got=%0d/%0d exp=50/50", unitLeftover, enemyLeftover); end
    do_ack();
  endtask

  initial begin
    rst = 1'b0; Start = 1'b0; Ack = 1'b0; wrEn = 1'b0; wrSide = 1'b0;
    wrIdx = '0; wrHp = '0; rdSide = 1'b0; rdIdx = '0;
    totalUnitDamage = '0; totalEnemyDamage = '0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_zero();
    test_wipe();
    test_skip_dead();
    test_handshake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
